// File: rtl/logic_accum_unit.sv
// logic_accum_unit: folds a frame of 1..MAX_LEN operands into a single result using
// a bitwise op (AND/OR/XOR/XNOR) selected at frame start.
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   start_i, op_i, len_i    frame start handshake (sampled only in idle)
//   busy_o                  high whenever a frame is in progress
//   in_valid_i, in_ready_o  operand stream handshake, bus_a_i carries data
//   out_valid_o, out_ready_i result handshake, bus_s_o carries the result
// All outputs are registered.
module logic_accum_unit #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] bus_a_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] bus_s_o
);

  localparam logic [1:0] OpAnd  = 2'b00;
  localparam logic [1:0] OpOr   = 2'b01;
  localparam logic [1:0] OpXnor = 2'b11;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] bus_s_q, bus_s_d;
  logic [LEN_W-1:0] len_sat;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    op_d    = op_q;
    len_sat = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d    = op_i;
          len_d   = len_sat;
          // Identity element: all ones for AND, zero for the others.
          acc_d   = (op_i == OpAnd) ? '1 : '0;
          cnt_d   = '0;
          state_d = (len_sat == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (in_valid_i && in_ready_q) begin
          unique case (op_q)
            OpAnd:   acc_d = acc_q & bus_a_i;
            OpOr:    acc_d = acc_q | bus_a_i;
            // XNOR folds as XOR; the inversion is applied once on output.
            default: acc_d = acc_q ^ bus_a_i;
          endcase
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are computed from next state so they can be registered.
    busy_d      = (state_d != StIdle);
    in_ready_d  = (state_d == StAccum);
    out_valid_d = (state_d == StDone);
    if (state_d == StDone) begin
      bus_s_d = (op_d == OpXnor) ? ~acc_d : acc_d;
    end else begin
      bus_s_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      op_q        <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      bus_s_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      op_q        <= op_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      bus_s_q     <= bus_s_d;
    end
  end

  assign busy_o      = busy_q;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign bus_s_o     = bus_s_q;

endmodule
